id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 64, datapath width of pc/rdata/imm fields.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: arst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: id_ctrl  input  10  decoded control bundle {alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}, MSB first.
REQ-005 SHALL have port: id_valid  input  1  ID holds a real instruction.
REQ-006 SHALL have ports: id_pc, id_rdata1, id_rdata2, id_imm  input  DATA_W each  ID operands.
REQ-007 SHALL have ports: id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-008 SHALL have port: id_func  input  4  {funct7[5], funct3} for ALU control.
REQ-009 SHALL have port: flush  input  1  taken branch/jump resolved downstream; kill ID.
REQ-010 SHALL have ports: ex_ctrl 10, ex_valid 1, ex_pc/ex_rdata1/ex_rdata2/ex_imm DATA_W, ex_rs1/ex_rs2/ex_rd 5, ex_func 4  output  registered copies for EX.
REQ-011 SHALL have port: stall  output  1  load-use hazard; hold PC and IF/ID.
REQ-012 SHALL have port: stall_count  output  32  saturating count of stall cycles.

Function
REQ-013 stall SHALL be combinational: id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush.
REQ-014 On each edge with flush=1, ex_valid and ex_ctrl SHALL be cleared to 0; data fields are don't-care (hold).
REQ-015 Else on each edge with stall=1, a bubble SHALL be inserted: ex_valid=0, ex_ctrl=0, data fields hold.
REQ-016 Else ALL ex_* fields SHALL capture id_* with 1-cycle latency; ex_valid=id_valid; ex_ctrl=id_valid ? id_ctrl : 0.
REQ-017 flush SHALL have priority over stall; simultaneous flush and hazard produce no stall and a cleared EX slot.
REQ-018 A load-use stall SHALL last exactly one cycle: the bubble clears ex_ctrl.mem_read, releasing stall next cycle with the same ID instruction captured.
REQ-019 Register x0 SHALL never cause a stall (ex_rd == 0 excluded).
REQ-020 stall_count SHALL increment by 1 on every edge where stall=1 and SHALL saturate at 32'hFFFFFFFF (no wrap).
REQ-021 ex_ctrl=0 SHALL be the architectural NOP encoding: no reg_write, mem_read, mem_write, branch or jump.

Reset
REQ-022 arst_n=0 SHALL asynchronously force every registered output (ex_*, stall_count) to 0, independent of clk.
REQ-023 Reset deassertion SHALL take effect on the next rising edge; first edge after release behaves per REQ-014..016.
REQ-024 Reset mid-stall SHALL discard the stall; stall reads 0 while arst_n=0 (ex_valid=0).

Structure
REQ-025 Control bundle field offsets, opcode constants and ALUOp encodings (00 add, 01 sub, 10 R-type, 11 jump) SHALL live in shared package cpu_pkg, also used by the control unit.
REQ-026 Hazard comparison SHALL be a combinational sub-module hazard_detect (inputs: id_valid, id_rs1, id_rs2, ex_valid, ex_mem_read, ex_rd, flush; output: stall).
REQ-027 The pipeline register and stall counter SHALL reside in id_ex_stage; no other state.

Verification
REQ-028 Pass-through: id_valid=1, id_ctrl=10'b10_0000_0010 (R-type, reg_write), id_rd=5 -> ex_ctrl/ex_rd equal inputs one edge later, stall=0.
REQ-029 Load-use: EX holds ld x7 (mem_read=1, ex_rd=7), ID add with rs1=7 -> stall=1 one cycle, ex_ctrl=0 next edge, add captured the following edge, stall_count=1.
REQ-030 x0 filter: EX ld with ex_rd=0, ID rs2=0 -> stall=0, no bubble.
REQ-031 Flush priority: hazard condition of REQ-029 plus flush=1 -> stall=0, ex_valid=0, ex_ctrl=0, stall_count unchanged.
REQ-032 Saturation: force stall_count to 32'hFFFFFFFE, two stall cycles -> 32'hFFFFFFFF, then stays 32'hFFFFFFFF.
REQ-033 Async reset: assert arst_n=0 between edges while ex_valid=1 -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: control bundle layout, ALUOp codes, major opcodes.
// Used by the decoder/control unit and by the pipeline registers that carry the bundle.
package cpu_pkg;

    localparam int CTRL_W = 10;

    // Bit positions inside the 10-bit control bundle, MSB first.
    localparam int CTRL_ALU_OP_HI  = 9;
    localparam int CTRL_ALU_OP_LO  = 8;
    localparam int CTRL_REG_DST    = 7;
    localparam int CTRL_BRANCH     = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_2_REG  = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_REG_WRITE  = 1;
    localparam int CTRL_JUMP       = 0;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
    } ctrl_t;

    // All-zero bundle doubles as the NOP: nothing writes, loads, stores or redirects.
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: combinational, zero latency.
// Asserts stall when the load in EX writes a register the ID instruction reads; flush wins.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       flush,
    output logic       stall
);

    logic rd_match;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign rd_match = (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign stall    = id_valid & ex_valid & ex_mem_read & rd_match & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating stall counter.
// 1-cycle latency ID->EX; stall holds upstream one cycle while EX takes a NOP bubble.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [9:0]        id_ctrl,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [3:0]        id_func,
    input  logic              flush,
    output logic [9:0]        ex_ctrl,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [3:0]        ex_func,
    output logic              stall,
    output logic [31:0]       stall_count
);

    logic [9:0]        ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, rdata1_q, rdata2_q, imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [3:0]        func_q;
    logic [31:0]       stall_count_q, stall_count_d;
    logic              bubble;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
        .ex_rd       (rd_q),
        .flush       (flush),
        .stall       (stall)
    );

    assign bubble = flush | stall;

    always_comb begin
        valid_d       = id_valid;
        ctrl_d        = id_valid ? id_ctrl : CTRL_NOP;
        stall_count_d = stall_count_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Operand fields only load on a real capture; a bubble leaves them holding.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_q        <= '0;
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            func_q        <= '0;
            stall_count_q <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            valid_q       <= valid_d;
            stall_count_q <= stall_count_d;
            if (!bubble) begin
                pc_q     <= id_pc;
                rdata1_q <= id_rdata1;
                rdata2_q <= id_rdata2;
                imm_q    <= id_imm;
                rs1_q    <= id_rs1;
                rs2_q    <= id_rs2;
                rd_q     <= id_rd;
                func_q   <= id_func;
            end
        end
    end

    assign ex_ctrl     = ctrl_q;
    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_func     = func_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX slot pushed when ID is driven, popped after the edge.
module tb_id_ex_stage;

    localparam int DW = 64;
    localparam logic [9:0] LD  = 10'b00_0011_0110;
    localparam logic [9:0] ADD = 10'b10_1000_0010;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [9:0]    id_ctrl;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic [3:0]    id_func;
    logic          flush;
    logic [9:0]    ex_ctrl;
    logic          ex_valid;
    logic [DW-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [3:0]    ex_func;
    logic          stall;
    logic [31:0]   stall_count;

    typedef struct packed {
        logic [9:0]    ctrl;
        logic          valid;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [3:0]    func;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [31:0]   cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        ex_exp;
    exp_t        e;
    exp_t        obs;
    logic [31:0] exp_cnt;
    int          errors = 0;
    int          checks = 0;

    id_ex_stage #(.DATA_W(DW)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .id_ctrl     (id_ctrl),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rdata1   (id_rdata1),
        .id_rdata2   (id_rdata2),
        .id_imm      (id_imm),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_func     (id_func),
        .flush       (flush),
        .ex_ctrl     (ex_ctrl),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rdata1   (ex_rdata1),
        .ex_rdata2   (ex_rdata2),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_func     (ex_func),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t r;
        r = '{ex_ctrl, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_func,
              ex_pc, ex_rdata1, ex_rdata2, ex_imm, stall_count};
        return r;
    endfunction

    // Expected EX slot when the currently driven ID instruction is captured.
    function automatic exp_t cap();
        exp_t r;
        r.ctrl  = id_valid ? id_ctrl : 10'd0;
        r.valid = id_valid;
        r.rs1   = id_rs1;
        r.rs2   = id_rs2;
        r.rd    = id_rd;
        r.func  = id_func;
        r.pc    = id_pc;
        r.rd1   = id_rdata1;
        r.rd2   = id_rdata2;
        r.imm   = id_imm;
        r.cnt   = exp_cnt;
        return r;
    endfunction

    // Expected EX slot after a bubble: control cleared, operands held.
    function automatic exp_t bubble_of(input exp_t prev);
        exp_t r;
        r       = prev;
        r.ctrl  = 10'd0;
        r.valid = 1'b0;
        r.cnt   = exp_cnt;
        return r;
    endfunction

    task automatic set_id(input logic v, input logic [9:0] c, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [DW-1:0] pc);
        id_valid  = v;
        id_ctrl   = c;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_pc     = pc;
        id_rdata1 = pc ^ 64'hA5A5_0000_1111_2222;
        id_rdata2 = pc ^ 64'h5A5A_3333_0000_4444;
        id_imm    = pc + 64'd77;
        id_func   = rd[3:0] ^ rs1[3:0];
    endtask

    task automatic test_reset();
        flush  = 1'b0;
        arst_n = 1'b1;
        set_id(1'b1, 10'h3FF, 5'd7, 5'd7, 5'd7, 64'hDEAD);
        #1 arst_n = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", obs); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        obs = observed();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_held: got %h want 0", obs); end
        @(negedge clk);
        arst_n  = 1'b1;
        exp_cnt = 32'd0;
        ex_exp  = '0;
    endtask

    task automatic test_passthrough();
        set_id(1'b1, 10'b10_0000_0010, 5'd1, 5'd2, 5'd5, 64'h100);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b want 0", stall); end
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pass_capture: got %h want %h", obs, e); end
        checks++;
        if (ex_ctrl !== 10'b10_0000_0010 || ex_rd !== 5'd5)
            begin errors++; $display("FAIL pass_ctrl_rd: got %h/%0d want 202/5", ex_ctrl, ex_rd); end
        @(negedge clk);
        set_id(1'b0, 10'h3FF, 5'd3, 5'd4, 5'd6, 64'h104);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL pass_invalid: got %h want %h", obs, e); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_id(1'b1, LD, 5'd2, 5'd0, 5'd7, 64'h200);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lu_load: got %h want %h", obs, e); end
        @(negedge clk);
        set_id(1'b1, ADD, 5'd7, 5'd3, 5'd9, 64'h204);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        exp_cnt = exp_cnt + 32'd1;
        sb.push_back(bubble_of(ex_exp));
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lu_bubble: got %h want %h", obs, e); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", stall); end
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lu_add_captured: got %h want %h", obs, e); end
        checks++;
        if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", stall_count); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        set_id(1'b1, LD, 5'd5, 5'd6, 5'd0, 64'h300);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL x0_load: got %h want %h", obs, e); end
        @(negedge clk);
        set_id(1'b1, ADD, 5'd4, 5'd0, 5'd3, 64'h304);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall); end
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL x0_no_bubble: got %h want %h", obs, e); end
    endtask

    task automatic test_flush_priority();
        @(negedge clk);
        set_id(1'b1, LD, 5'd2, 5'd0, 5'd7, 64'h400);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fl_load: got %h want %h", obs, e); end
        @(negedge clk);
        set_id(1'b1, ADD, 5'd7, 5'd3, 5'd9, 64'h404);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b want 0", stall); end
        sb.push_back(bubble_of(ex_exp));
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL fl_cleared: got %h want %h", obs, e); end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_id(1'(i != 3), 10'($urandom) & 10'h3DF, 5'($urandom), 5'($urandom),
                   5'($urandom), {32'($urandom), 32'($urandom)});
            sb.push_back(cap());
            @(posedge clk); #1;
            e = sb.pop_front(); obs = observed(); ex_exp = e;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b_%0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        dut.stall_count_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
        set_id(1'b1, LD, 5'd1, 5'd2, 5'd7, 64'h500);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sat_preload: got %h want %h", obs, e); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_id(1'b1, ADD, 5'd7 + 5'(k), 5'd0, 5'd9, 64'h504 + 64'(k * 8));
            #1;
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall_%0d: got %b want 1", k, stall); end
            exp_cnt = 32'hFFFF_FFFF;
            sb.push_back(bubble_of(ex_exp));
            @(posedge clk); #1;
            e = sb.pop_front(); obs = observed(); ex_exp = e;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL sat_bubble_%0d: got %h want %h", k, obs, e); end
            if (k == 0) begin
                @(negedge clk);
                set_id(1'b1, LD, 5'd1, 5'd2, 5'd8, 64'h508);
                sb.push_back(cap());
                @(posedge clk); #1;
                e = sb.pop_front(); obs = observed(); ex_exp = e;
                checks++;
                if (obs !== e) begin errors++; $display("FAIL sat_load2: got %h want %h", obs, e); end
            end
        end
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (stall_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", stall_count); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sat_after: got %h want %h", obs, e); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_id(1'b1, LD, 5'd1, 5'd2, 5'd7, 64'h600);
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e || ex_valid !== 1'b1) begin errors++; $display("FAIL ar_load: got %h want %h", obs, e); end
        @(negedge clk);
        set_id(1'b1, ADD, 5'd7, 5'd3, 5'd9, 64'h604);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL ar_pre_stall: got %b want 1", stall); end
        #2 arst_n = 1'b0;
        #1;
        obs = observed();
        checks++;
        if (obs !== '0 || stall !== 1'b0)
            begin errors++; $display("FAIL ar_immediate: got %h stall %b want 0", obs, stall); end
        @(negedge clk);
        arst_n  = 1'b1;
        exp_cnt = 32'd0;
        ex_exp  = '0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ar_release_stall: got %b want 0", stall); end
        sb.push_back(cap());
        @(posedge clk); #1;
        e = sb.pop_front(); obs = observed(); ex_exp = e;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL ar_first_edge: got %h want %h", obs, e); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0();
        test_flush_priority();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
